controle_jogo: RTL and testbench

CONTROLE_JOGO -- requirements
Module: controle_jogo

---
 rtl/controle_jogo.sv | 128 ++++++++++++
 tb/tb_controle_jogo.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/controle_jogo.sv
// Game flow controller: start, launch delay, pause, ball loss, lives and score.
// Every output is a register loaded from the next-state logic.
module controle_jogo #(
  parameter int VIDAS_INICIAIS    = 3,
  parameter int ESPERA_QUADROS    = 60,
  parameter int PONTOS_POR_ACERTO = 1
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       tecla_iniciar,
  input  logic       tecla_pausa,
  input  logic       tick_quadro,
  input  logic       bola_perdida,
  input  logic       inimigo_atingido,
  output logic [2:0] estado,
  output logic       pausa,
  output logic       reiniciarJogo,
  output logic       iniciarBola,
  output logic [1:0] vidas,
  output logic [9:0] pontos,
  output logic       game_over
);

  typedef enum logic [2:0] {
    OCIOSO       = 3'd0,
    PREPARA      = 3'd1,
    JOGANDO      = 3'd2,
    PAUSADO      = 3'd3,
    BOLA_PERDIDA = 3'd4,
    FIM          = 3'd5
  } estado_t;

  localparam logic [1:0]  VI   = 2'(VIDAS_INICIAIS);
  localparam logic [8:0]  ESP  = 9'(ESPERA_QUADROS);
  localparam logic [10:0] PTS  = 11'(PONTOS_POR_ACERTO);
  localparam logic [10:0] PMAX = 11'd999;

  estado_t    st, st_n;
  logic       ini_q, pau_q;
  logic       ini_ev, pau_ev;
  logic [7:0] cnt, cnt_n;
  logic [8:0] cnt_inc;
  logic [10:0] soma;
  logic [1:0] vidas_n;
  logic [9:0] pontos_n;
  logic       rj_n, ib_n;

  assign ini_ev  = tecla_iniciar & ~ini_q;
  assign pau_ev  = tecla_pausa & ~pau_q;
  assign cnt_inc = {1'b0, cnt} + 9'd1;
  assign soma    = {1'b0, pontos} + PTS;
  assign estado  = st;

  always_comb begin
    st_n     = st;
    cnt_n    = cnt;
    vidas_n  = vidas;
    pontos_n = pontos;
    rj_n     = 1'b0;
    ib_n     = 1'b0;
    case (st)
      OCIOSO, FIM: begin
        if (ini_ev) begin
          st_n     = PREPARA;
          rj_n     = 1'b1;
          vidas_n  = VI;
          pontos_n = '0;
          cnt_n    = '0;
        end
      end
      PREPARA: begin
        if (tick_quadro) begin
          cnt_n = cnt_inc[7:0];
          if (cnt_inc >= ESP) begin
            st_n = JOGANDO;
            ib_n = 1'b1;
          end
        end
      end
      JOGANDO: begin
        if (inimigo_atingido)
          pontos_n = (soma > PMAX) ? PMAX[9:0] : soma[9:0];
        // Losing the ball outranks a simultaneous pause request
        if (bola_perdida)
          st_n = BOLA_PERDIDA;
        else if (pau_ev)
          st_n = PAUSADO;
      end
      PAUSADO: begin
        if (pau_ev)
          st_n = JOGANDO;
      end
      BOLA_PERDIDA: begin
        vidas_n = vidas - 2'd1;
        cnt_n   = '0;
        st_n    = (vidas == 2'd1) ? FIM : PREPARA;
      end
      default: st_n = OCIOSO;
    endcase
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      st            <= OCIOSO;
      ini_q         <= 1'b1;
      pau_q         <= 1'b1;
      cnt           <= '0;
      vidas         <= VI;
      pontos        <= '0;
      pausa         <= 1'b1;
      reiniciarJogo <= 1'b0;
      iniciarBola   <= 1'b0;
      game_over     <= 1'b0;
    end else begin
      st            <= st_n;
      ini_q         <= tecla_iniciar;
      pau_q         <= tecla_pausa;
      cnt           <= cnt_n;
      vidas         <= vidas_n;
      pontos        <= pontos_n;
      pausa         <= (st_n != JOGANDO);
      reiniciarJogo <= rj_n;
      iniciarBola   <= ib_n;
      game_over     <= (st_n == FIM);
    end
  end

endmodule

// File: tb/tb_controle_jogo.sv
// Directed bench for controle_jogo: expected output vectors are queued
// per step and checked against the DUT after each clock edge.
module tb_controle_jogo;

  logic       clk = 1'b0;
  logic       reset;
  logic       ini, pau, tk, bp, hit;
  logic [2:0] estado;
  logic       pausa, rj, ib, go;
  logic [1:0] vidas;
  logic [9:0] pontos;

  typedef struct packed {
    logic [2:0] es;
    logic       pz;
    logic       rj;
    logic       ib;
    logic [1:0] vi;
    logic [9:0] po;
    logic       go;
  } exp_t;

  exp_t ex;
  exp_t sb[$];
  int   n_assert = 0;
  int   n_fail   = 0;

  controle_jogo #(
    .VIDAS_INICIAIS(3),
    .ESPERA_QUADROS(2),
    .PONTOS_POR_ACERTO(1)
  ) dut (
    .CLOCK_50(clk),
    .reset(reset),
    .tecla_iniciar(ini),
    .tecla_pausa(pau),
    .tick_quadro(tk),
    .bola_perdida(bp),
    .inimigo_atingido(hit),
    .estado(estado),
    .pausa(pausa),
    .reiniciarJogo(rj),
    .iniciarBola(ib),
    .vidas(vidas),
    .pontos(pontos),
    .game_over(go)
  );

  always #5 clk = ~clk;

  task automatic drive(input logic i, p, t, b, h);
    ini = i; pau = p; tk = t; bp = b; hit = h;
  endtask

  task automatic set_ex(input logic [2:0] es, input logic pz, r, ib_e,
                        input logic [1:0] vi, input logic [9:0] po,
                        input logic g);
    ex = '{es: es, pz: pz, rj: r, ib: ib_e, vi: vi, po: po, go: g};
  endtask

  task automatic check(input string tag);
    exp_t e, o;
    e = sb.pop_front();
    o = '{es: estado, pz: pausa, rj: rj, ib: ib, vi: vidas, po: pontos, go: go};
    n_assert++;
    assert (o === e) else begin
      n_fail++;
      $error("FAIL %s: got es=%0d pz=%0b rj=%0b ib=%0b vi=%0d po=%0d go=%0b, expected es=%0d pz=%0b rj=%0b ib=%0b vi=%0d po=%0d go=%0b",
             tag, o.es, o.pz, o.rj, o.ib, o.vi, o.po, o.go,
             e.es, e.pz, e.rj, e.ib, e.vi, e.po, e.go);
    end
  endtask

  task automatic now(input string tag);
    sb.push_back(ex);
    check(tag);
  endtask

  task automatic step(input string tag);
    sb.push_back(ex);
    @(posedge clk);
    #1;
    check(tag);
  endtask

  initial begin
    reset = 1'b1;
    drive(0, 0, 0, 0, 0);
    #2;
    set_ex(0, 1, 0, 0, 3, 0, 0);
    now("reset_async");
    step("reset_held");
    reset = 1'b0;
    step("idle");

    drive(1, 0, 0, 0, 0);
    set_ex(1, 1, 1, 0, 3, 0, 0);
    step("start");
    drive(1, 0, 0, 0, 0);
    set_ex(1, 1, 0, 0, 3, 0, 0);
    step("prep_rj_off");
    drive(0, 0, 1, 0, 0);
    step("prep_tick1");
    drive(0, 0, 1, 0, 0);
    set_ex(2, 0, 0, 1, 3, 0, 0);
    step("launch");
    drive(0, 0, 0, 0, 0);
    set_ex(2, 0, 0, 0, 3, 0, 0);
    step("play_ib_off");
    drive(0, 0, 0, 0, 1);
    set_ex(2, 0, 0, 0, 3, 1, 0);
    step("hit1");

    drive(0, 1, 0, 1, 1);
    set_ex(4, 1, 0, 0, 3, 2, 0);
    step("combo_lost");
    drive(0, 0, 0, 0, 0);
    set_ex(1, 1, 0, 0, 2, 2, 0);
    step("combo_prep");
    drive(0, 0, 1, 0, 0);
    step("relaunch_t1");
    set_ex(2, 0, 0, 1, 2, 2, 0);
    step("relaunch");
    drive(0, 0, 0, 0, 0);
    set_ex(2, 0, 0, 0, 2, 2, 0);
    step("play2");

    drive(0, 1, 0, 0, 0);
    set_ex(3, 1, 0, 0, 2, 2, 0);
    step("pause");
    step("pause_held");
    drive(1, 1, 1, 1, 1);
    step("pause_ignore");
    drive(0, 0, 0, 0, 0);
    step("pause_release");
    drive(0, 1, 0, 0, 0);
    set_ex(2, 0, 0, 0, 2, 2, 0);
    step("resume");
    drive(0, 0, 0, 0, 0);
    step("resumed");

    drive(0, 0, 0, 1, 0);
    set_ex(4, 1, 0, 0, 2, 2, 0);
    step("lost2");
    drive(0, 0, 0, 0, 0);
    set_ex(1, 1, 0, 0, 1, 2, 0);
    step("lost2_prep");
    drive(0, 0, 1, 0, 0);
    step("l2_t1");
    set_ex(2, 0, 0, 1, 1, 2, 0);
    step("l2_launch");
    drive(0, 0, 0, 1, 0);
    set_ex(4, 1, 0, 0, 1, 2, 0);
    step("lost3");
    drive(0, 0, 0, 0, 0);
    set_ex(5, 1, 0, 0, 0, 2, 1);
    step("game_over");
    drive(0, 0, 1, 1, 1);
    step("fim_frozen");

    drive(1, 0, 0, 0, 0);
    set_ex(1, 1, 1, 0, 3, 0, 0);
    step("restart");
    drive(0, 0, 1, 0, 0);
    set_ex(1, 1, 0, 0, 3, 0, 0);
    step("rs_t1");
    set_ex(2, 0, 0, 1, 3, 0, 0);
    step("rs_launch");

    drive(0, 0, 0, 0, 1);
    for (int i = 1; i <= 1001; i++) begin
      set_ex(2, 0, 0, 0, 3, (i > 999) ? 10'd999 : 10'(i), 0);
      step("saturate");
    end
    drive(0, 0, 0, 0, 0);

    drive(1, 0, 0, 0, 0);
    #2;
    reset = 1'b1;
    #1;
    set_ex(0, 1, 0, 0, 3, 0, 0);
    now("reset_mid_game");
    step("reset_key_held");
    reset = 1'b0;
    step("key_held_release1");
    step("key_held_release2");
    drive(0, 0, 0, 0, 0);
    step("key_released");
    drive(1, 0, 0, 0, 0);
    set_ex(1, 1, 1, 0, 3, 0, 0);
    step("key_pressed");

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
